// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register with valid/ready handshake, load-use stall (including a load
// still waiting in MEM) and wrong-path squash of the ID instruction on a taken EX branch.
//
// Handshake: a transfer happens on a clock edge where valid and ready are both high.
// Upstream (ID->EX) transfers when in_valid & in_ready; downstream (EX->MEM) when
// out_valid & out_ready. in_ready never depends on in_valid. With FlushE high, in_ready
// is forced high so ID consumes its wrong-path instruction, and nothing is captured.
module idex_pipe_reg #(
   parameter int XLEN           = 32,
   parameter int REG_LENGTH     = 5,
   parameter int PC_SRC_LENGTH  = 2,
   parameter int CTRL_W         = 16,
   parameter int PC_SRC_PCPLUS4 = 0
) (
   input  logic                     clk,
   input  logic                     rstn,

   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [XLEN-1:0]          PCD,
   input  logic [XLEN-1:0]          RD1D,
   input  logic [XLEN-1:0]          RD2D,
   input  logic [XLEN-1:0]          ImmExtD,
   input  logic [REG_LENGTH-1:0]    Rs1D,
   input  logic [REG_LENGTH-1:0]    Rs2D,
   input  logic [REG_LENGTH-1:0]    RdD,
   input  logic                     RegWriteD,
   input  logic                     MemReadD,
   input  logic [PC_SRC_LENGTH-1:0] PCSrcD,
   input  logic [CTRL_W-1:0]        CtrlD,

   input  logic                     FlushE,
   input  logic                     MemAdvM,

   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          PCE,
   output logic [XLEN-1:0]          RD1E,
   output logic [XLEN-1:0]          RD2E,
   output logic [XLEN-1:0]          ImmExtE,
   output logic [REG_LENGTH-1:0]    Rs1E,
   output logic [REG_LENGTH-1:0]    Rs2E,
   output logic [REG_LENGTH-1:0]    RdE,
   output logic                     RegWriteE,
   output logic                     MemReadE,
   output logic [PC_SRC_LENGTH-1:0] PCSrcE,
   output logic [CTRL_W-1:0]        CtrlE,

   output logic                     dbgLuState,
   output logic [REG_LENGTH-1:0]    dbgPendRd
);

   localparam logic [0:0] LU_IDLE = 1'b0;
   localparam logic [0:0] LU_M    = 1'b1;

   logic [0:0]            luState;
   logic [REG_LENGTH-1:0] pendRd;

   logic drain;
   logic accept;
   logic isLoadE;
   logic exHit;
   logic memHit;
   logic luHit;

   assign drain   = out_valid & out_ready;
   assign isLoadE = MemReadE & RegWriteE;

   // Load sitting in EX whose result the ID instruction needs.
   assign exHit = out_valid & isLoadE & (RdE != '0) &
                  ((RdE == Rs1D) | (RdE == Rs2D));

   // Load that already left EX but has not yet reached WB, so nothing can forward it.
   assign memHit = (luState == LU_M) & (pendRd != '0) &
                   ((pendRd == Rs1D) | (pendRd == Rs2D));

   assign luHit = exHit | memHit;

   assign in_ready = FlushE | ((~out_valid | out_ready) & ~luHit);
   assign accept   = in_valid & in_ready & ~FlushE;

   // Payload: only loaded on accept, otherwise holds (including across a drain).
   always_ff @(posedge clk) begin
      if (!rstn) begin
         PCE     <= '0;
         RD1E    <= '0;
         RD2E    <= '0;
         ImmExtE <= '0;
         Rs1E    <= '0;
         Rs2E    <= '0;
         RdE     <= '0;
         PCSrcE  <= PC_SRC_LENGTH'(PC_SRC_PCPLUS4);
         CtrlE   <= '0;
      end else if (accept) begin
         PCE     <= PCD;
         RD1E    <= RD1D;
         RD2E    <= RD2D;
         ImmExtE <= ImmExtD;
         Rs1E    <= Rs1D;
         Rs2E    <= Rs2D;
         RdE     <= RdD;
         PCSrcE  <= PCSrcD;
         CtrlE   <= CtrlD;
      end
   end

   // Valid and side-effect flags clear on a drain so a bubble never looks like a writer.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         out_valid <= 1'b0;
         RegWriteE <= 1'b0;
         MemReadE  <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         RegWriteE <= RegWriteD;
         MemReadE  <= MemReadD;
      end else if (drain) begin
         out_valid <= 1'b0;
         RegWriteE <= 1'b0;
         MemReadE  <= 1'b0;
      end
   end

   // Tracks one load between EX and WB; EX/MEM holds out_ready low while MEM is occupied.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         luState <= LU_IDLE;
         pendRd  <= '0;
      end else begin
         case (luState)
            LU_IDLE: begin
               if (drain & isLoadE) begin
                  luState <= LU_M;
                  pendRd  <= RdE;
               end
            end
            LU_M: begin
               if (drain & isLoadE) begin
                  luState <= LU_M;
                  pendRd  <= RdE;
               end else if (MemAdvM) begin
                  luState <= LU_IDLE;
               end
            end
            default: begin
               luState <= LU_IDLE;
            end
         endcase
      end
   end

   assign dbgLuState = luState;
   assign dbgPendRd  = pendRd;

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Directed bench for idex_pipe_reg: a per-cycle vector table covering throughput,
// load-use stalls, x0 loads, flushes and backpressure, then a reset taken mid-stall.
module tb_idex_pipe_reg;

   localparam logic [31:0] PC_BASE = 32'h8000_0000;

   logic        clk;
   logic        rstn;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] PCD, RD1D, RD2D, ImmExtD;
   logic [4:0]  Rs1D, Rs2D, RdD;
   logic        RegWriteD, MemReadD;
   logic [1:0]  PCSrcD;
   logic [15:0] CtrlD;
   logic        FlushE, MemAdvM;
   logic        out_valid, out_ready;
   logic [31:0] PCE, RD1E, RD2E, ImmExtE;
   logic [4:0]  Rs1E, Rs2E, RdE;
   logic        RegWriteE, MemReadE;
   logic [1:0]  PCSrcE;
   logic [15:0] CtrlE;
   logic        dbgLuState;
   logic [4:0]  dbgPendRd;

   int n_compared;
   int n_mismatched;

   idex_pipe_reg dut (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid), .in_ready(in_ready),
      .PCD(PCD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
      .RegWriteD(RegWriteD), .MemReadD(MemReadD), .PCSrcD(PCSrcD), .CtrlD(CtrlD),
      .FlushE(FlushE), .MemAdvM(MemAdvM),
      .out_valid(out_valid), .out_ready(out_ready),
      .PCE(PCE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
      .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .RegWriteE(RegWriteE), .MemReadE(MemReadE), .PCSrcE(PCSrcE), .CtrlE(CtrlE),
      .dbgLuState(dbgLuState), .dbgPendRd(dbgPendRd)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [31:0] pc;
      logic [4:0]  rs1, rs2, rd;
      logic        rw, mr, fl, adv, ordy;
      logic        eIrdy, eOv;
      logic [31:0] ePce;
      logic        eRw, eMr, eLu;
   } vec_t;

   vec_t vt[30];

   function automatic vec_t mk(input logic v, input logic [7:0] pcOff,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic rw, input logic mr, input logic fl, input logic adv,
                               input logic ordy, input logic eIrdy, input logic eOv,
                               input logic [7:0] ePcOff, input logic eRw, input logic eMr,
                               input logic eLu);
      vec_t r;
      r.v = v; r.pc = PC_BASE + 32'(pcOff); r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
      r.rw = rw; r.mr = mr; r.fl = fl; r.adv = adv; r.ordy = ordy;
      r.eIrdy = eIrdy; r.eOv = eOv; r.ePce = PC_BASE + 32'(ePcOff);
      r.eRw = eRw; r.eMr = eMr; r.eLu = eLu;
      return r;
   endfunction

   // scoreboard check
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // driver
   task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic rw,
                        input logic mr, input logic fl, input logic adv, input logic ordy);
      in_valid  = v;
      PCD       = pc;
      RD1D      = ~pc;
      RD2D      = pc + 32'd1;
      ImmExtD   = pc ^ 32'h0000_5a5a;
      CtrlD     = pc[17:2];
      PCSrcD    = (!rw && !mr) ? 2'b01 : 2'b00;
      Rs1D      = rs1;
      Rs2D      = rs2;
      RdD       = rd;
      RegWriteD = rw;
      MemReadD  = mr;
      FlushE    = fl;
      MemAdvM   = adv;
      out_ready = ordy;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, ".lu_state"},  32'(dbgLuState), 32'd0);
      chk({tag, ".pend_rd"},   32'(dbgPendRd), 32'd0);
      chk({tag, ".PCE"},       PCE, 32'd0);
      chk({tag, ".RD1E"},      RD1E, 32'd0);
      chk({tag, ".RD2E"},      RD2E, 32'd0);
      chk({tag, ".ImmExtE"},   ImmExtE, 32'd0);
      chk({tag, ".Rs1E"},      32'(Rs1E), 32'd0);
      chk({tag, ".Rs2E"},      32'(Rs2E), 32'd0);
      chk({tag, ".RdE"},       32'(RdE), 32'd0);
      chk({tag, ".RegWriteE"}, 32'(RegWriteE), 32'd0);
      chk({tag, ".MemReadE"},  32'(MemReadE), 32'd0);
      chk({tag, ".PCSrcE"},    32'(PCSrcE), 32'd0);
      chk({tag, ".CtrlE"},     32'(CtrlE), 32'd0);
   endtask

   initial begin
      n_compared   = 0;
      n_mismatched = 0;

      //            v  pc   rs1 rs2 rd rw mr fl adv rdy | irdy ov  pce  rw mr lu
      vt[0]  = mk(1, 8'h00, 2,  3,  1, 1, 0, 0, 0, 1,   1,  1, 8'h00, 1, 0, 0);
      vt[1]  = mk(1, 8'h04, 1,  1,  2, 1, 0, 0, 0, 1,   1,  1, 8'h04, 1, 0, 0);
      vt[2]  = mk(1, 8'h08, 2,  2,  3, 1, 0, 0, 0, 1,   1,  1, 8'h08, 1, 0, 0);
      vt[3]  = mk(1, 8'h0C, 3,  0,  5, 1, 1, 0, 0, 1,   1,  1, 8'h0C, 1, 1, 0);
      vt[4]  = mk(1, 8'h10, 5,  0,  6, 1, 0, 0, 0, 1,   0,  0, 8'h0C, 0, 0, 1);
      vt[5]  = mk(1, 8'h10, 5,  0,  6, 1, 0, 0, 0, 1,   0,  0, 8'h0C, 0, 0, 1);
      vt[6]  = mk(1, 8'h10, 5,  0,  6, 1, 0, 0, 0, 1,   0,  0, 8'h0C, 0, 0, 1);
      vt[7]  = mk(1, 8'h10, 5,  0,  6, 1, 0, 0, 1, 1,   0,  0, 8'h0C, 0, 0, 0);
      vt[8]  = mk(1, 8'h10, 5,  0,  6, 1, 0, 0, 0, 1,   1,  1, 8'h10, 1, 0, 0);
      // load to x0 then use of x0
      vt[9]  = mk(1, 8'h14, 0,  0,  0, 1, 1, 0, 0, 1,   1,  1, 8'h14, 1, 1, 0);
      vt[10] = mk(1, 8'h18, 0,  0,  7, 1, 0, 0, 0, 1,   1,  1, 8'h18, 1, 0, 1);
      vt[11] = mk(1, 8'h1C, 0,  0,  8, 1, 0, 0, 1, 1,   1,  1, 8'h1C, 1, 0, 0);
      // branch held under flush, then drained
      vt[12] = mk(1, 8'h20, 1,  2,  0, 0, 0, 0, 0, 1,   1,  1, 8'h20, 0, 0, 0);
      vt[13] = mk(1, 8'h24, 0,  0,  1, 1, 0, 1, 0, 0,   1,  1, 8'h20, 0, 0, 0);
      vt[14] = mk(1, 8'h28, 0,  0,  1, 1, 0, 1, 0, 0,   1,  1, 8'h20, 0, 0, 0);
      vt[15] = mk(1, 8'h2C, 0,  0,  1, 1, 0, 1, 0, 1,   1,  0, 8'h20, 0, 0, 0);
      vt[16] = mk(1, 8'h30, 0,  0,  9, 1, 0, 0, 0, 1,   1,  1, 8'h30, 1, 0, 0);
      // flush with lu_hit, load drains
      vt[17] = mk(1, 8'h34, 9,  0, 10, 1, 1, 0, 0, 1,   1,  1, 8'h34, 1, 1, 0);
      vt[18] = mk(1, 8'h38, 10, 0, 15, 1, 0, 1, 0, 1,   1,  0, 8'h34, 0, 0, 1);
      vt[19] = mk(1, 8'h3C, 0,  0, 11, 1, 0, 0, 1, 1,   1,  1, 8'h3C, 1, 0, 0);
      // flush with lu_hit, load held
      vt[20] = mk(1, 8'h40, 0,  0, 12, 1, 1, 0, 0, 1,   1,  1, 8'h40, 1, 1, 0);
      vt[21] = mk(1, 8'h44, 0, 12, 16, 1, 0, 1, 0, 0,   1,  1, 8'h40, 1, 1, 0);
      vt[22] = mk(1, 8'h48, 0, 12, 16, 1, 0, 0, 0, 0,   0,  1, 8'h40, 1, 1, 0);
      vt[23] = mk(1, 8'h48, 0, 12, 16, 1, 0, 0, 0, 1,   0,  0, 8'h40, 0, 0, 1);
      vt[24] = mk(0, 8'h4C, 0,  0,  0, 0, 0, 0, 1, 1,   1,  0, 8'h40, 0, 0, 0);
      // plain backpressure
      vt[25] = mk(1, 8'h4C, 0,  0, 17, 1, 0, 0, 0, 1,   1,  1, 8'h4C, 1, 0, 0);
      vt[26] = mk(1, 8'h50, 0,  0, 18, 1, 0, 0, 0, 0,   0,  1, 8'h4C, 1, 0, 0);
      vt[27] = mk(1, 8'h50, 0,  0, 18, 1, 0, 0, 0, 1,   1,  1, 8'h50, 1, 0, 0);
      // leave a load in MEM with a valid instruction in EX
      vt[28] = mk(1, 8'h54, 0,  0, 13, 1, 1, 0, 0, 1,   1,  1, 8'h54, 1, 1, 0);
      vt[29] = mk(1, 8'h58, 0,  0, 14, 1, 0, 0, 0, 1,   1,  1, 8'h58, 1, 0, 1);

      rstn = 1'b0;
      drive(0, 32'd0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk_reset_state("reset");

      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         rstn = 1'b1;
         drive(vt[i].v, vt[i].pc, vt[i].rs1, vt[i].rs2, vt[i].rd,
               vt[i].rw, vt[i].mr, vt[i].fl, vt[i].adv, vt[i].ordy);
         #1;
         chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vt[i].eIrdy));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vt[i].eOv));
         chk($sformatf("v%0d.PCE", i), PCE, vt[i].ePce);
         chk($sformatf("v%0d.RD1E", i), RD1E, ~vt[i].ePce);
         chk($sformatf("v%0d.RD2E", i), RD2E, vt[i].ePce + 32'd1);
         chk($sformatf("v%0d.ImmExtE", i), ImmExtE, vt[i].ePce ^ 32'h0000_5a5a);
         chk($sformatf("v%0d.CtrlE", i), 32'(CtrlE), 32'(vt[i].ePce[17:2]));
         chk($sformatf("v%0d.RegWriteE", i), 32'(RegWriteE), 32'(vt[i].eRw));
         chk($sformatf("v%0d.MemReadE", i), 32'(MemReadE), 32'(vt[i].eMr));
         chk($sformatf("v%0d.lu_state", i), 32'(dbgLuState), 32'(vt[i].eLu));
      end

      // reset while LU_M with a valid EX entry held under backpressure
      @(negedge clk);
      rstn = 1'b0;
      drive(1, PC_BASE + 32'h5C, 13, 0, 19, 1, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      chk_reset_state("midstall_reset");

      @(negedge clk);
      rstn = 1'b1;
      drive(1, PC_BASE + 32'h5C, 13, 0, 19, 1, 0, 0, 0, 1);
      #1;
      chk("post_reset.in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      chk("post_reset.out_valid", 32'(out_valid), 32'd1);
      chk("post_reset.PCE", PCE, PC_BASE + 32'h5C);
      chk("post_reset.RdE", 32'(RdE), 32'd19);
      chk("post_reset.Rs1E", 32'(Rs1E), 32'd13);
      chk("post_reset.Rs2E", 32'(Rs2E), 32'd0);
      chk("post_reset.PCSrcE", 32'(PCSrcE), 32'd0);
      chk("post_reset.lu_state", 32'(dbgLuState), 32'd0);

      // final report
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
